// File: rtl/atm_pkg.sv
// atm_pkg: status codes, ASCII key constants, menu choice and collector state types shared by the ATM key-entry logic.
package atm_pkg;
   typedef enum logic [3:0] {
      ST_NONE          = 4'b0000,
      ST_ACC_FOUND     = 4'b0001,
      ST_ACC_NOT_FOUND = 4'b0010,
      ST_WRONG_PIN     = 4'b0011,
      ST_BALANCE       = 4'b0100,
      ST_NO_FUNDS      = 4'b0101,
      ST_TXN_OK        = 4'b0110,
      ST_EXIT          = 4'b0111,
      ST_INPUT_COMPLETE= 4'b1000,
      ST_TIMEOUT       = 4'b1001
   } status_e;
   typedef enum logic [1:0] {
      MENU_BALANCE  = 2'd0,
      MENU_CONVERT  = 2'd1,
      MENU_WITHDRAW = 2'd2,
      MENU_TRANSFER = 2'd3
   } menu_e;
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;
   localparam logic [7:0] KEY_ENTER = 8'h0D;
   localparam logic [7:0] KEY_BKSP  = 8'h08;
   localparam logic [7:0] KEY_QUIT  = 8'h71;
   localparam logic [7:0] KEY_B     = 8'h62;
   localparam logic [7:0] KEY_C     = 8'h63;
   localparam logic [7:0] KEY_W     = 8'h77;
   localparam logic [7:0] KEY_T     = 8'h74;
endpackage

// File: rtl/keypad_field_collector_if.sv
// keypad_field_collector_if: key stream in, collected field out; master = decoder/consumer side, slave = collector.
interface keypad_field_collector_if
   import atm_pkg::*;
#(
   parameter int MAX_DIGITS = 4,
   parameter int DIGIT_W    = 4
);
   logic                                 start;
   logic                                 menu_mode;
   logic                                 key_valid;
   logic [7:0]                           ascii_code;
   logic                                 busy;
   logic                                 field_valid;
   logic [MAX_DIGITS*DIGIT_W-1:0]        field_value;
   logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count;
   menu_e                                menu_sel;
   status_e                              status_code;
   logic                                 exit_req;
   logic                                 reject;
   modport master (
      output start, menu_mode, key_valid, ascii_code,
      input  busy, field_valid, field_value, digit_count, menu_sel, status_code, exit_req, reject
   );
   modport slave (
      input  start, menu_mode, key_valid, ascii_code,
      output busy, field_valid, field_value, digit_count, menu_sel, status_code, exit_req, reject
   );
endinterface

// File: rtl/ascii_key_classify.sv
// ascii_key_classify: combinational decode of one ASCII code into digit / edit / quit / menu classes.
module ascii_key_classify
   import atm_pkg::*;
(
   input  logic [7:0] ascii_i,
   output logic       is_digit_o,
   output logic [3:0] digit_o,
   output logic       is_enter_o,
   output logic       is_bksp_o,
   output logic       is_quit_o,
   output logic       is_menu_o,
   output menu_e      menu_code_o
);
   always_comb begin
      is_digit_o  = ascii_i >= 8'h30 && ascii_i <= 8'h39;
      digit_o     = ascii_i[3:0];
      is_enter_o  = ascii_i == KEY_ENTER;
      is_bksp_o   = ascii_i == KEY_BKSP;
      is_quit_o   = ascii_i == KEY_QUIT;
      is_menu_o   = ascii_i == KEY_B || ascii_i == KEY_C || ascii_i == KEY_W || ascii_i == KEY_T;
      menu_code_o = ascii_i == KEY_C ? MENU_CONVERT :
                    ascii_i == KEY_W ? MENU_WITHDRAW :
                    ascii_i == KEY_T ? MENU_TRANSFER : MENU_BALANCE;
   end
endmodule

// File: rtl/keypad_field_collector.sv
// keypad_field_collector: collects one BCD or menu field from the ASCII key stream.
// Optional idle abort when KEYPAD_TIMEOUT_EN is defined.
module keypad_field_collector
   import atm_pkg::*;
#(
   parameter int MAX_DIGITS  = 4,
   parameter int MIN_DIGITS  = 4,
   parameter int DIGIT_W     = 4,
   parameter int TIMEOUT_CYC = 50_000_000
)(
   input logic                    clk,
   input logic                    rst_n,
   keypad_field_collector_if.slave kp
);
   localparam int FW = MAX_DIGITS * DIGIT_W;
   localparam int CW = $clog2(MAX_DIGITS + 1);
   state_e         state_q, state_d;
   logic [FW-1:0]  val_q, val_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           mode_q, mode_d;
   menu_e          sel_q, sel_d;
   status_e        stat_q, stat_d;
   logic           fv_q, fv_d, ex_q, ex_d, rej_q, rej_d;
   logic           is_digit, is_enter, is_bksp, is_quit, is_menu, timeout;
   logic [3:0]     digit;
   menu_e          menu_code;
   ascii_key_classify u_cls (
      .ascii_i     (kp.ascii_code),
      .is_digit_o  (is_digit),
      .digit_o     (digit),
      .is_enter_o  (is_enter),
      .is_bksp_o   (is_bksp),
      .is_quit_o   (is_quit),
      .is_menu_o   (is_menu),
      .menu_code_o (menu_code)
   );
`ifdef KEYPAD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   always_comb begin
      tmo_d   = (kp.start || kp.key_valid || state_q != S_COLLECT) ? '0 : tmo_q + 1'b1;
      timeout = state_q == S_COLLECT && !kp.start && !kp.key_valid && tmo_q == TW'(TIMEOUT_CYC - 1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
`else
   assign timeout = 1'b0;
`endif
   // start takes priority over any key in the same cycle, in every state
   always_comb begin
      state_d = state_q;
      val_d   = val_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      sel_d   = sel_q;
      stat_d  = stat_q;
      fv_d    = 1'b0;
      ex_d    = 1'b0;
      rej_d   = 1'b0;
      if (kp.start) begin
         state_d = S_COLLECT;
         val_d   = '0;
         cnt_d   = '0;
         mode_d  = kp.menu_mode;
      end else if (state_q == S_COLLECT) begin
         if (kp.key_valid && is_quit || timeout) begin
            ex_d    = 1'b1;
            stat_d  = timeout ? ST_TIMEOUT : ST_EXIT;
            val_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end else if (kp.key_valid && mode_q) begin
            if (is_menu) begin
               sel_d   = menu_code;
               stat_d  = ST_INPUT_COMPLETE;
               fv_d    = 1'b1;
               state_d = S_DONE;
            end else rej_d = 1'b1;
         end else if (kp.key_valid) begin
            if (is_digit && cnt_q < CW'(MAX_DIGITS)) begin
               val_d = (val_q << DIGIT_W) | FW'(digit);
               cnt_d = cnt_q + 1'b1;
            end else if (is_bksp && cnt_q != '0) begin
               val_d = val_q >> DIGIT_W;
               cnt_d = cnt_q - 1'b1;
            end else if (is_enter && cnt_q >= CW'(MIN_DIGITS)) begin
               stat_d  = ST_INPUT_COMPLETE;
               fv_d    = 1'b1;
               state_d = S_DONE;
            end else rej_d = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         val_q   <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         sel_q   <= MENU_BALANCE;
         stat_q  <= ST_NONE;
         fv_q    <= 1'b0;
         ex_q    <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         val_q   <= val_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         sel_q   <= sel_d;
         stat_q  <= stat_d;
         fv_q    <= fv_d;
         ex_q    <= ex_d;
         rej_q   <= rej_d;
      end
   assign kp.busy        = state_q == S_COLLECT;
   assign kp.field_valid = fv_q;
   assign kp.field_value = val_q;
   assign kp.digit_count = cnt_q;
   assign kp.menu_sel    = sel_q;
   assign kp.status_code = stat_q;
   assign kp.exit_req    = ex_q;
   assign kp.reject      = rej_q;
endmodule

// File: tb/tb_keypad_field_collector.sv
// tb_keypad_field_collector: directed key sequences checked every cycle against a queue-based field model.
module tb_keypad_field_collector;
   import atm_pkg::*;
   localparam int MAXD = 4;
   localparam int MIND = 4;
   localparam int TMO  = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   keypad_field_collector_if #(.MAX_DIGITS(MAXD), .DIGIT_W(4)) kp ();
   keypad_field_collector #(.MAX_DIGITS(MAXD), .MIN_DIGITS(MIND), .DIGIT_W(4), .TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp.slave)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference: held digits as a queue (oldest first), phase 0=idle 1=collecting 2=done
   int q[$];
   int phase = 0, m_sel = 0, m_stat = 0, idle = 0;
   bit m_menu = 0, m_fv = 0, m_ex = 0, m_rej = 0;
   function automatic logic [63:0] packed_val();
      logic [63:0] v = 0;
      foreach (q[i]) v = (v << 4) | 64'(q[i]);
      return v;
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete(); phase = 0; m_sel = 0; m_stat = 0; idle = 0;
         m_menu = 0; m_fv = 0; m_ex = 0; m_rej = 0;
      end else begin
         m_fv = 0; m_ex = 0; m_rej = 0;
         if (kp.start) begin
            phase = 1; q.delete(); m_menu = kp.menu_mode; idle = 0;
         end else if (phase == 1 && kp.key_valid) begin
            idle = 0;
            if (kp.ascii_code == "q") begin
               m_ex = 1; m_stat = 7; q.delete(); phase = 0;
            end else if (m_menu) begin
               case (kp.ascii_code)
                  "b": m_sel = 0;
                  "c": m_sel = 1;
                  "w": m_sel = 2;
                  "t": m_sel = 3;
                  default: m_rej = 1;
               endcase
               if (!m_rej) begin m_fv = 1; m_stat = 8; phase = 2; end
            end else if (kp.ascii_code >= "0" && kp.ascii_code <= "9") begin
               if (q.size() < MAXD) q.push_back(int'(kp.ascii_code) - 48);
               else m_rej = 1;
            end else if (kp.ascii_code == 8'h08) begin
               if (q.size() > 0) void'(q.pop_back());
               else m_rej = 1;
            end else if (kp.ascii_code == 8'h0D) begin
               if (q.size() >= MIND) begin m_fv = 1; m_stat = 8; phase = 2; end
               else m_rej = 1;
            end else m_rej = 1;
         end else if (phase == 1) begin
`ifdef KEYPAD_TIMEOUT_EN
            idle++;
            if (idle == TMO) begin m_ex = 1; m_stat = 9; q.delete(); phase = 0; idle = 0; end
`endif
         end
      end
   end
   always @(negedge clk) begin
      chk("busy", kp.busy, phase == 1);
      chk("field_valid", kp.field_valid, m_fv);
      chk("field_value", kp.field_value, packed_val());
      chk("digit_count", kp.digit_count, q.size());
      chk("menu_sel", kp.menu_sel, m_sel);
      chk("status_code", kp.status_code, m_stat);
      chk("exit_req", kp.exit_req, m_ex);
      chk("reject", kp.reject, m_rej);
   end
   task automatic strt(input bit mode);
      @(negedge clk); kp.start = 1'b1; kp.menu_mode = mode;
      @(negedge clk); kp.start = 1'b0;
   endtask
   task automatic key(input logic [7:0] c);
      @(negedge clk); kp.key_valid = 1'b1; kp.ascii_code = c;
      @(negedge clk); kp.key_valid = 1'b0;
   endtask
   task automatic keys(input string s);
      for (int i = 0; i < s.len(); i++) key(s[i]);
   endtask
   initial begin
      kp.start = 1'b0; kp.menu_mode = 1'b0; kp.key_valid = 1'b0; kp.ascii_code = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_value", kp.field_value, 16'h0);
      chk("rst_status", kp.status_code, 4'b0000);
      rst_n = 1'b1;
      key("5");
      chk("idle_key_silent", kp.reject, 1'b0);
      strt(0);
      keys("7777"); key(8'h0D);
      chk("t1_value", kp.field_value, 16'h7777);
      chk("t1_count", kp.digit_count, 4);
      chk("t1_fv", kp.field_valid, 1'b1);
      chk("t1_status", kp.status_code, 4'b1000);
      chk("t1_busy", kp.busy, 1'b0);
      @(negedge clk);
      chk("t1_fv_one_cycle", kp.field_valid, 1'b0);
      key("9");
      chk("done_hold", kp.field_value, 16'h7777);
      strt(0);
      key(8'h08);
      chk("t2_bksp_empty", kp.reject, 1'b1);
      keys("123"); key(8'h08); keys("45"); key(8'h0D);
      chk("t2_value", kp.field_value, 16'h1245);
      strt(0);
      keys("1234"); key("5");
      chk("t3_overflow_rej", kp.reject, 1'b1);
      chk("t3_value", kp.field_value, 16'h1234);
      strt(0);
      keys("12"); key(8'h0D);
      chk("t3_short_rej", kp.reject, 1'b1);
      chk("t3_short_nofv", kp.field_valid, 1'b0);
      @(negedge clk); kp.start = 1'b1; kp.key_valid = 1'b1; kp.ascii_code = "8";
      @(negedge clk); kp.start = 1'b0; kp.key_valid = 1'b0;
      chk("restart_drop", kp.digit_count, 0);
      strt(1);
      key("x");
      chk("t4_x_rej", kp.reject, 1'b1);
      key("w");
      chk("t4_sel", kp.menu_sel, 2);
      chk("t4_fv", kp.field_valid, 1'b1);
      strt(1); key("t");
      chk("t4_sel_t", kp.menu_sel, 3);
      strt(0);
      key("3"); key("q");
      chk("t5_exit", kp.exit_req, 1'b1);
      chk("t5_status", kp.status_code, 4'b0111);
      chk("t5_value", kp.field_value, 16'h0);
      chk("t5_idle", kp.busy, 1'b0);
      strt(0);
      keys("12");
      #2 rst_n = 1'b0;
      #1;
      chk("async_value", kp.field_value, 16'h0);
      chk("async_count", kp.digit_count, 0);
      chk("async_busy", kp.busy, 1'b0);
      chk("async_status", kp.status_code, 4'b0000);
      @(negedge clk); rst_n = 1'b1;
`ifdef KEYPAD_TIMEOUT_EN
      strt(0);
      repeat (TMO) @(negedge clk);
      chk("tmo_exit", kp.exit_req, 1'b1);
      chk("tmo_status", kp.status_code, 4'b1001);
      strt(0);
      repeat (TMO - 2) @(negedge clk);
      key("5");
      chk("tmo_key_wins", kp.exit_req, 1'b0);
      chk("tmo_key_count", kp.digit_count, 1);
`endif
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
